// File: rtl/pe_tile_param_pkg.sv
// pe_tile_param_pkg
//   Shared definitions for the parametrised PE tile: config region codes,
//   switch-box select codes and CLB operation/config types.
package pe_tile_param_pkg;

    // Config regions (config_addr[31:24])
    localparam logic [7:0] REG_CLB   = 8'd4;
    localparam logic [7:0] REG_CB1   = 8'd5;
    localparam logic [7:0] REG_CB0   = 8'd6;
    localparam logic [7:0] REG_SB    = 8'd7;
    localparam logic [7:0] REG_SBREG = 8'd8;

    // Switch-box output select codes; 5..7 also drive 0
    localparam logic [2:0] SB_ZERO = 3'd0;
    localparam logic [2:0] SB_TRK0 = 3'd1;
    localparam logic [2:0] SB_TRK1 = 3'd2;
    localparam logic [2:0] SB_TRK2 = 3'd3;
    localparam logic [2:0] SB_PE   = 3'd4;

    typedef enum logic [1:0] {
        CLB_AND = 2'd0,
        CLB_OR  = 2'd1,
        CLB_XOR = 2'd2,
        CLB_NOT = 2'd3
    } clb_op_e;

    // CLB config word layout: [2] reg_en, [1:0] op
    typedef struct packed {
        logic    reg_en;
        clb_op_e op;
    } clb_cfg_t;

    function automatic logic region_valid(input logic [7:0] r);
        return (r >= REG_CLB) && (r <= REG_SBREG);
    endfunction

endpackage

// File: rtl/sb_param.sv
// sb_param
//   Switch box: one 3-bit-select mux per output track plus an optional
//   output register per track.
// Ports
//   clk_i, rst_ni : clock, async active-low reset (clears output registers)
//   in_i          : side-gated input tracks, side s track t at ((s*T+t)*W)
//   pe_i          : CLB result
//   sel_i         : 3 bits per output o=s*T+t at [3o +: 3]
//   mask_i        : bit o = 1 -> output o comes from its register
//   out_o         : output tracks, same packing as in_i
module sb_param
    import pe_tile_param_pkg::*;
#(
    parameter int         W       = 1,
    parameter int         T       = 4,
    parameter logic [3:0] SIDE_EN = 4'b1111
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4*T*W-1:0] in_i,
    input  logic [W-1:0]     pe_i,
    input  logic [4*T*3-1:0] sel_i,
    input  logic [4*T-1:0]   mask_i,
    output logic [4*T*W-1:0] out_o
);

    for (genvar s = 0; s < 4; s++) begin : g_s
        // The three "other" sides of side s, in ascending order
        localparam int S0 = (s > 0) ? 0 : 1;
        localparam int S1 = (s > 1) ? 1 : 2;
        localparam int S2 = (s > 2) ? 2 : 3;

        for (genvar t = 0; t < T; t++) begin : g_t
            localparam int O = s * T + t;

            logic [W-1:0] out_d;
            logic [W-1:0] out_q;

            always_comb begin
                out_d = '0;
                case (sel_i[O*3 +: 3])
                    SB_TRK0: out_d = in_i[(S0*T+t)*W +: W];
                    SB_TRK1: out_d = in_i[(S1*T+t)*W +: W];
                    SB_TRK2: out_d = in_i[(S2*T+t)*W +: W];
                    SB_PE:   out_d = pe_i;
                    default: out_d = '0;
                endcase
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) out_q <= '0;
                else         out_q <= out_d;
            end

            // Disabled sides are tied off regardless of configuration
            assign out_o[O*W +: W] = !SIDE_EN[s] ? '0 :
                                     (mask_i[O] ? out_q : out_d);
        end
    end

endmodule

// File: rtl/pe_tile_param.sv
// pe_tile_param
//   Parametrised PE tile: switch box, two connect boxes (CB0 on side 0,
//   CB1 on side 1) and a 2-input bitwise CLB, with a shared config bus and
//   registered readback.
// Ports
//   clk, reset   : clock, async active-low reset
//   config_addr  : [31:24] region, [23:16] word index, [15:0] tile id
//   config_data  : write data
//   config_we    : write strobe
//   config_rd    : read strobe
//   config_rdata : registered readback, 0 when not addressed
//   tile_id      : static tile id
//   in_wire      : side s track t at ((s*T+t)*W)
//   out_wire     : same packing
module pe_tile_param
    import pe_tile_param_pkg::*;
#(
    parameter int         W       = 1,
    parameter int         T       = 4,
    parameter logic [3:0] SIDE_EN = 4'b1111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      config_addr,
    input  logic [31:0]      config_data,
    input  logic             config_we,
    input  logic             config_rd,
    output logic [31:0]      config_rdata,
    input  logic [15:0]      tile_id,
    input  logic [4*T*W-1:0] in_wire,
    output logic [4*T*W-1:0] out_wire
);

    localparam int NO       = 4 * T;
    localparam int SB_WORDS = NO / 8;
    localparam int MK_WORDS = (NO + 31) / 32;
    localparam int CBW      = $clog2(2 * T);

    // ---------------- config decode ----------------
    logic [7:0] region;
    int         widx;
    logic       hit;

    assign region = config_addr[31:24];
    assign widx   = {24'd0, config_addr[23:16]};
    assign hit    = (config_addr[15:0] == tile_id) && region_valid(region);

    logic [NO*3-1:0] sel_q,  sel_d;
    logic [NO-1:0]   mask_q, mask_d;
    logic [CBW-1:0]  cb0_q,  cb0_d;
    logic [CBW-1:0]  cb1_q,  cb1_d;
    clb_cfg_t        clb_q,  clb_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     rd_word;

    // Readback is taken from the current _q values, so a same-cycle write
    // and read of one word returns the old contents.
    always_comb begin
        sel_d   = sel_q;
        mask_d  = mask_q;
        cb0_d   = cb0_q;
        cb1_d   = cb1_q;
        clb_d   = clb_q;
        rd_word = '0;
        if (hit) begin
            case (region)
                REG_SB: if (widx < SB_WORDS) begin
                    for (int j = 0; j < 8; j++) begin
                        rd_word[3*j +: 3] = sel_q[(widx*8+j)*3 +: 3];
                        if (config_we) sel_d[(widx*8+j)*3 +: 3] = config_data[3*j +: 3];
                    end
                end
                REG_SBREG: if (widx < MK_WORDS) begin
                    for (int j = 0; j < 32; j++) begin
                        if (widx*32 + j < NO) begin
                            rd_word[j] = mask_q[widx*32+j];
                            if (config_we) mask_d[widx*32+j] = config_data[j];
                        end
                    end
                end
                REG_CB0: if (widx == 0) begin
                    rd_word[CBW-1:0] = cb0_q;
                    if (config_we) cb0_d = config_data[CBW-1:0];
                end
                REG_CB1: if (widx == 0) begin
                    rd_word[CBW-1:0] = cb1_q;
                    if (config_we) cb1_d = config_data[CBW-1:0];
                end
                REG_CLB: if (widx == 0) begin
                    rd_word[2:0] = clb_q;
                    if (config_we) clb_d = clb_cfg_t'(config_data[2:0]);
                end
                default: ;
            endcase
        end
        rdata_d = (config_rd && hit) ? rd_word : '0;
    end

    assign config_rdata = rdata_q;

    // ---------------- datapath ----------------
    logic [4*T*W-1:0] in_g;
    logic [W-1:0]     op0, op1, clb_res, pe_q, pe_out;

    for (genvar s = 0; s < 4; s++) begin : g_gate
        assign in_g[s*T*W +: T*W] = SIDE_EN[s] ? in_wire[s*T*W +: T*W] : '0;
    end

    // Connect boxes: codes 0..T-1 pick an input track, T..2T-1 the tile's
    // own output track on the same side (loops only break via registers).
    always_comb begin
        op0 = '0;
        op1 = '0;
        for (int t = 0; t < T; t++) begin
            if (cb0_q == CBW'(t))     op0 = in_g[t*W +: W];
            if (cb0_q == CBW'(t + T)) op0 = out_wire[t*W +: W];
            if (cb1_q == CBW'(t))     op1 = in_g[(T+t)*W +: W];
            if (cb1_q == CBW'(t + T)) op1 = out_wire[(T+t)*W +: W];
        end
    end

    always_comb begin
        clb_res = '0;
        case (clb_q.op)
            CLB_AND: clb_res = op0 & op1;
            CLB_OR:  clb_res = op0 | op1;
            CLB_XOR: clb_res = op0 ^ op1;
            CLB_NOT: clb_res = ~op0;
        endcase
    end

    assign pe_out = clb_q.reg_en ? pe_q : clb_res;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q   <= '0;
            mask_q  <= '0;
            cb0_q   <= '0;
            cb1_q   <= '0;
            clb_q   <= '0;
            rdata_q <= '0;
            pe_q    <= '0;
        end else begin
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            cb0_q   <= cb0_d;
            cb1_q   <= cb1_d;
            clb_q   <= clb_d;
            rdata_q <= rdata_d;
            pe_q    <= clb_res;
        end
    end

    sb_param #(.W(W), .T(T), .SIDE_EN(SIDE_EN)) u_sb (
        .clk_i  (clk),
        .rst_ni (reset),
        .in_i   (in_g),
        .pe_i   (pe_out),
        .sel_i  (sel_q),
        .mask_i (mask_q),
        .out_o  (out_wire)
    );

endmodule

// File: tb/tb_pe_tile_param.sv
// tb_pe_tile_param
//   Directed bench: tile A (id 1, all sides on) and edge tile B (id 2,
//   side 0 off) share the config bus. T=4, W=8.
module tb_pe_tile_param;

    localparam int W = 8;
    localparam int T = 4;
    localparam int N = 4 * T * W;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   config_addr, config_data;
    logic          config_we, config_rd;
    logic [31:0]   rdata_a, rdata_b;
    logic [N-1:0]  in_a, in_b, out_a, out_b;
    logic [31:0]   ra, rb;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    pe_tile_param #(.W(W), .T(T), .SIDE_EN(4'b1111)) u_a (
        .clk(clk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
        .config_we(config_we), .config_rd(config_rd), .config_rdata(rdata_a),
        .tile_id(16'h0001), .in_wire(in_a), .out_wire(out_a)
    );

    pe_tile_param #(.W(W), .T(T), .SIDE_EN(4'b1110)) u_b (
        .clk(clk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
        .config_we(config_we), .config_rd(config_rd), .config_rdata(rdata_b),
        .tile_id(16'h0002), .in_wire(in_b), .out_wire(out_b)
    );

    function automatic logic [31:0] trk(input logic [N-1:0] v, input int s, input int t);
        return 32'(v[(s*T+t)*W +: W]);
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [7:0] rg, input logic [7:0] wi, input logic [15:0] id,
                          input logic [31:0] d);
        @(negedge clk);
        config_addr = {rg, wi, id};
        config_data = d;
        config_we   = 1'b1;
        @(negedge clk);
        config_we   = 1'b0;
    endtask

    task automatic cfg_rd(input logic [7:0] rg, input logic [7:0] wi, input logic [15:0] id,
                          output logic [31:0] oa, output logic [31:0] ob);
        @(negedge clk);
        config_addr = {rg, wi, id};
        config_rd   = 1'b1;
        @(negedge clk);
        config_rd   = 1'b0;
        oa = rdata_a;
        ob = rdata_b;
    endtask

    task automatic cfg_wrrd(input logic [7:0] rg, input logic [7:0] wi, input logic [15:0] id,
                            input logic [31:0] d, output logic [31:0] oa);
        @(negedge clk);
        config_addr = {rg, wi, id};
        config_data = d;
        config_we   = 1'b1;
        config_rd   = 1'b1;
        @(negedge clk);
        config_we   = 1'b0;
        config_rd   = 1'b0;
        oa = rdata_a;
    endtask

    initial begin
        reset = 1'b0;
        config_addr = '0; config_data = '0; config_we = 1'b0; config_rd = 1'b0;
        in_a = '0; in_b = '0;

        // ---- reset state ----
        #1;
        chk("reset_out_a", out_a, '0);
        chk("reset_out_b", out_b, '0);
        chk("reset_rdata", 128'(rdata_a), '0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        cfg_rd(8'd7, 8'd0, 16'h0001, ra, rb);
        chk("rd_sb0_after_reset", 128'(ra), '0);

        // ---- SB select 1 on output 0 picks side1 track0, combinationally ----
        in_a[(1*T+0)*W +: W] = 8'hA5;
        cfg_wr(8'd7, 8'd0, 16'h0001, 32'h1);
        #1;
        chk("sb_sel1_comb", 128'(trk(out_a, 0, 0)), 128'h00A5);
        chk("sb_sel0_zero", 128'(trk(out_a, 0, 1)), '0);
        in_a[(1*T+0)*W +: W] = 8'h3C;
        #1;
        chk("sb_sel1_follow", 128'(trk(out_a, 0, 0)), 128'h003C);
        // ---- out-reg mask bit0: one-cycle latency ----
        cfg_wr(8'd8, 8'd0, 16'h0001, 32'h1);
        in_a[(1*T+0)*W +: W] = 8'h77;
        #1;
        chk("sb_reg_hold", 128'(trk(out_a, 0, 0)), 128'h003C);
        @(posedge clk); #1;
        chk("sb_reg_update", 128'(trk(out_a, 0, 0)), 128'h0077);
        cfg_rd(8'd7, 8'd0, 16'h0001, ra, rb);
        chk("rd_sb0", 128'(ra), 128'h1);
        cfg_rd(8'd8, 8'd0, 16'h0001, ra, rb);
        chk("rd_mask0", 128'(ra), 128'h1);

        // ---- CB0=2 (in side0 trk2), CB1=5 (out side1 trk1 <- in side2 trk1) ----
        in_a[(0*T+2)*W +: W] = 8'h0F;
        in_a[(1*T+1)*W +: W] = 8'hFF;
        in_a[(2*T+1)*W +: W] = 8'hFF;
        cfg_wr(8'd7, 8'd1, 16'h0001, 32'h0000_0800);   // output 11 (side2 trk3) = pe_out
        cfg_wr(8'd6, 8'd0, 16'h0001, 32'd2);
        cfg_wr(8'd5, 8'd0, 16'h0001, 32'd5);
        cfg_wr(8'd7, 8'd0, 16'h0001, 32'h0001_0001);   // output 5 sel 2 -> side2 trk1
        #1;
        chk("sb_sel2", 128'(trk(out_a, 1, 1)), 128'h00FF);
        chk("clb_and_comb", 128'(trk(out_a, 2, 3)), 128'h000F);
        cfg_wr(8'd4, 8'd0, 16'h0001, 32'd6);           // XOR, reg_en
        @(posedge clk); #1;
        chk("clb_xor_reg", 128'(trk(out_a, 2, 3)), 128'h00F0);
        @(negedge clk);
        in_a[(0*T+2)*W +: W] = 8'h00;
        #1;
        chk("clb_reg_hold", 128'(trk(out_a, 2, 3)), 128'h00F0);
        @(posedge clk); #1;
        chk("clb_reg_update", 128'(trk(out_a, 2, 3)), 128'h00FF);
        cfg_wr(8'd4, 8'd0, 16'h0001, 32'd0);           // AND, combinational
        in_a[(0*T+2)*W +: W] = 8'h3C;
        #1;
        chk("clb_and", 128'(trk(out_a, 2, 3)), 128'h003C);
        cfg_wr(8'd4, 8'd0, 16'h0001, 32'd1);
        #1;
        chk("clb_or", 128'(trk(out_a, 2, 3)), 128'h00FF);
        cfg_wr(8'd4, 8'd0, 16'h0001, 32'd3);
        #1;
        chk("clb_not", 128'(trk(out_a, 2, 3)), 128'h00C3);

        // ---- misses: wrong tile id, bad region, word index out of range ----
        cfg_wr(8'd7, 8'd0, 16'h0003, 32'h0);
        cfg_rd(8'd7, 8'd0, 16'h0001, ra, rb);
        chk("miss_id_nochange", 128'(ra), 128'h0001_0001);
        cfg_wr(8'd9, 8'd0, 16'h0001, 32'hFFFF_FFFF);
        cfg_rd(8'd9, 8'd0, 16'h0001, ra, rb);
        chk("rd_region9", 128'(ra), '0);
        cfg_rd(8'd7, 8'd0, 16'h0003, ra, rb);
        chk("rd_wrong_id", 128'(ra), '0);
        cfg_wr(8'd7, 8'd2, 16'h0001, 32'hFFFF_FFFF);
        cfg_rd(8'd7, 8'd2, 16'h0001, ra, rb);
        chk("rd_word_oob", 128'(ra), '0);
        cfg_rd(8'd7, 8'd1, 16'h0001, ra, rb);
        chk("oob_no_alias", 128'(ra), 128'h0800);
        #1;
        chk("miss_out_kept", 128'(trk(out_a, 2, 3)), 128'h00C3);

        // ---- same-cycle write+read returns old value ----
        cfg_wrrd(8'd4, 8'd0, 16'h0001, 32'd5, ra);
        chk("wrrd_old", 128'(ra), 128'h3);
        cfg_rd(8'd4, 8'd0, 16'h0001, ra, rb);
        chk("wrrd_new", 128'(ra), 128'h5);

        // ---- async reset mid-run with an out-reg set and a read in flight ----
        @(negedge clk);
        config_addr = {8'd7, 8'd0, 16'h0001};
        config_rd   = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_rdata", 128'(rdata_a), 128'h0001_0001);
        chk("pre_reset_out", 128'(trk(out_a, 0, 0)), 128'h0077);
        reset = 1'b0;
        #1;
        chk("midrst_out_a", out_a, '0);
        chk("midrst_rdata", 128'(rdata_a), '0);
        config_rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cfg_rd(8'd7, 8'd0, 16'h0001, ra, rb);
        chk("rd_sb0_after_midrst", 128'(ra), '0);
        chk("out_after_midrst", out_a, '0);

        // ---- edge tile: side 0 disabled ----
        for (int i = 0; i < 4*T; i++) in_b[i*W +: W] = 8'h10 + 8'(i);
        cfg_wr(8'd7, 8'd0, 16'h0002, 32'h0024_9249);   // outputs 0..7 sel 1
        #1;
        chk("edge_side0_side1_zero", 128'(out_b[2*T*W-1:0]), '0);
        cfg_wr(8'd7, 8'd0, 16'h0002, 32'h0024_A492);
        #1;
        chk("edge_side0_zero", 128'(out_b[T*W-1:0]), '0);
        chk("edge_s1t0_from_s2", 128'(trk(out_b, 1, 0)), 128'h0018);
        chk("edge_s1t1_from_s0", 128'(trk(out_b, 1, 1)), '0);
        chk("tile_a_untouched", out_a, '0);
        cfg_rd(8'd7, 8'd0, 16'h0002, ra, rb);
        chk("edge_rd_sb0", 128'(rb), 128'h0024_A492);
        chk("other_tile_rdata0", 128'(ra), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
